countdown_timer_ctrl: RTL

Controller that sequences a free-running clock prescaler into a programmable countdown timer. It derives a TICK_HZ tick from `clock`, loads a tick count, and counts it down while running. It supports pause and stop, and reports expiry with a one-cycle `done` pulse and a sticky `expired` level. It sits between the user-facing control logic (buttons/FSMs) and any block that needs timed events, replacing ad-hoc per-block divider counters.

---
 rtl/timer_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/countdown_timer_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and sizing helpers for the countdown timer controller and its prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  localparam int TIMER_CNT_W_DEFAULT = 16;

  // A divide-by-1 prescaler still needs a 1-bit counter to stay legal.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; wrap is combinational so the controller can register tick with the count update.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  output logic wrap
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    wrap    = advance && (count_q == LAST);
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      count_d = wrap ? '0 : count_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer driven by a CLK_FREQ_HZ/TICK_HZ prescaler; all outputs registered.
// Define TIMER_AUTO_RELOAD_EN to reload the captured count on expiry instead of stopping.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int CNT_W       = TIMER_CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [CNT_W-1:0] load_value,
  output logic             busy,
  output logic             paused,
  output logic [CNT_W-1:0] remaining,
  output logic             tick,
  output logic             done,
  output logic             expired
);

  localparam int DIV = (TICK_HZ > 0) ? (CLK_FREQ_HZ / TICK_HZ) : 0;

  if (DIV < 1) begin : g_div_check
    $error("countdown_timer_ctrl: CLK_FREQ_HZ / TICK_HZ must be >= 1");
  end

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d, paused_q, paused_d;
  logic             tick_q, tick_d, done_q, done_d, expired_q, expired_d;
  logic             presc_clear, presc_adv, presc_wrap;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [CNT_W-1:0] load_q, load_d;
`endif

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (presc_clear),
    .advance (presc_adv),
    .wrap    (presc_wrap)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    presc_clear = 1'b0;
    presc_adv   = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    load_d      = load_q;
`endif
    if (stop) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      presc_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_EXPIRED: begin
          if (start) begin
            remaining_d = load_value;
            presc_clear = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            load_d      = load_value;
`endif
            if (load_value != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN, ST_PAUSE: begin
          // A paused edge never advances the prescaler, even if it sits at DIV-1.
          if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            state_d   = ST_RUN;
            presc_adv = 1'b1;
            if (presc_wrap) begin
              tick_d = 1'b1;
              if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                done_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                remaining_d = load_q;
`else
                state_d = ST_EXPIRED;
`endif
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d    = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    paused_d  = (state_d == ST_PAUSE);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      expired_q   <= expired_d;
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) load_q <= '0;
    else          load_q <= load_d;
  end
`endif

  assign busy      = busy_q;
  assign paused    = paused_q;
  assign remaining = remaining_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign expired   = expired_q;

endmodule
